// File: rtl/wb_skid_stage_if.sv
// wb_skid_stage_if: MEM-to-WB handshake, payload and writeback result bundle
interface wb_skid_stage_if #(
  parameter int D_WIDTH   = 32,
  parameter int RF_SIZE   = 5,
  parameter int CNT_WIDTH = 16
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [D_WIDTH-1:0]   alu_out_mem;
  logic [D_WIDTH-1:0]   r_data_mem;
  logic [RF_SIZE-1:0]   rd_mem;
  logic                 reg_write_mem;
  logic                 mem_to_reg_mem;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [D_WIDTH-1:0]   alu_out_wb;
  logic [D_WIDTH-1:0]   mem_data_wb;
  logic [RF_SIZE-1:0]   rd_wb;
  logic                 reg_write_wb;
  logic                 mem_to_reg_wb;
  logic [D_WIDTH-1:0]   wb_data;
  logic [CNT_WIDTH-1:0] stall_cnt;

  // Stage side: consumes MEM payload, produces WB payload
  modport slave (
    input  in_valid, alu_out_mem, r_data_mem, rd_mem, reg_write_mem, mem_to_reg_mem,
    input  flush, out_ready,
    output in_ready, out_valid, alu_out_wb, mem_data_wb, rd_wb, reg_write_wb,
    output mem_to_reg_wb, wb_data, stall_cnt
  );

  // Surrounding pipeline side
  modport master (
    output in_valid, alu_out_mem, r_data_mem, rd_mem, reg_write_mem, mem_to_reg_mem,
    output flush, out_ready,
    input  in_ready, out_valid, alu_out_wb, mem_data_wb, rd_wb, reg_write_wb,
    input  mem_to_reg_wb, wb_data, stall_cnt
  );
endinterface

// File: rtl/wb_skid_stage.sv
// wb_skid_stage: MEM/WB boundary register with 2-entry skid buffer, flush and result mux
module wb_skid_stage #(
  parameter int D_WIDTH   = 32,
  parameter int RF_SIZE   = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wb_skid_stage_if.slave        bus
);
  typedef enum logic [1:0] {EMPTY, MAIN, FULL} state_t;

  state_t               state, state_nx;
  logic                 main_valid, skid_valid, acc, drn;
  logic                 ld_in_main, ld_skid_main, ld_in_skid;
  logic [D_WIDTH-1:0]   m_alu, m_mem, s_alu, s_mem;
  logic [RF_SIZE-1:0]   m_rd, s_rd;
  logic                 m_rw, m_m2r, s_rw, s_m2r;
  logic [CNT_WIDTH-1:0] cnt;

  assign main_valid = state != EMPTY;
  assign skid_valid = state == FULL;
  assign acc        = bus.in_valid && !skid_valid && !bus.flush;
  assign drn        = main_valid && bus.out_ready;

  // occupancy register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;

  // next occupancy and slot load strobes; flush squashes everything including input
  always_comb begin
    state_nx     = state;
    ld_in_main   = 1'b0;
    ld_skid_main = 1'b0;
    ld_in_skid   = 1'b0;
    if (bus.flush) state_nx = EMPTY;
    else
      case (state)
        EMPTY: begin
          ld_in_main = acc;
          state_nx   = acc ? MAIN : EMPTY;
        end
        MAIN: begin
          ld_in_main = drn && acc;
          ld_in_skid = !drn && acc;
          state_nx   = acc ? (drn ? MAIN : FULL) : (drn ? EMPTY : MAIN);
        end
        default: begin
          ld_skid_main = drn;
          state_nx     = drn ? MAIN : FULL;
        end
      endcase
  end

  // main slot payload: refilled from skid first to keep order
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_alu <= '0;
      m_mem <= '0;
      m_rd  <= '0;
      m_rw  <= 1'b0;
      m_m2r <= 1'b0;
    end else if (ld_skid_main) begin
      m_alu <= s_alu;
      m_mem <= s_mem;
      m_rd  <= s_rd;
      m_rw  <= s_rw;
      m_m2r <= s_m2r;
    end else if (ld_in_main) begin
      m_alu <= bus.alu_out_mem;
      m_mem <= bus.r_data_mem;
      m_rd  <= bus.rd_mem;
      m_rw  <= bus.reg_write_mem;
      m_m2r <= bus.mem_to_reg_mem;
    end

  // skid slot payload: catches the one instruction accepted while main is stalled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s_alu <= '0;
      s_mem <= '0;
      s_rd  <= '0;
      s_rw  <= 1'b0;
      s_m2r <= 1'b0;
    end else if (ld_in_skid) begin
      s_alu <= bus.alu_out_mem;
      s_mem <= bus.r_data_mem;
      s_rd  <= bus.rd_mem;
      s_rw  <= bus.reg_write_mem;
      s_m2r <= bus.mem_to_reg_mem;
    end

  // saturating count of cycles WB refused a valid instruction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                       cnt <= '0;
    else if (main_valid && !bus.out_ready && ~&cnt)   cnt <= cnt + 1'b1;

  assign bus.in_ready      = !skid_valid;
  assign bus.out_valid     = main_valid;
  assign bus.alu_out_wb    = m_alu;
  assign bus.mem_data_wb   = m_mem;
  assign bus.rd_wb         = m_rd;
  assign bus.reg_write_wb  = m_rw && main_valid;
  assign bus.mem_to_reg_wb = m_m2r;
  assign bus.wb_data       = m_m2r ? m_mem : m_alu;
  assign bus.stall_cnt     = cnt;
endmodule

// File: tb/tb_wb_skid_stage.sv
// tb_wb_skid_stage: directed self-checking bench for wb_skid_stage
module tb_wb_skid_stage;
  logic clk, rst_n;
  int   checks = 0, failures = 0;

  wb_skid_stage_if #(.D_WIDTH(32), .RF_SIZE(5), .CNT_WIDTH(4)) bus ();

  wb_skid_stage #(.D_WIDTH(32), .RF_SIZE(5), .CNT_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rdat, input logic m2r);
    bus.in_valid       = v;
    bus.rd_mem         = rd;
    bus.alu_out_mem    = alu;
    bus.r_data_mem     = rdat;
    bus.mem_to_reg_mem = m2r;
    bus.reg_write_mem  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    checks += 6;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    if (bus.reg_write_wb !== 1'b0 || bus.mem_to_reg_wb !== 1'b0) begin failures++; $display("FAIL reset_ctrl got rw=%b m2r=%b want 0 0", bus.reg_write_wb, bus.mem_to_reg_wb); end
    if (bus.rd_wb !== 5'd0) begin failures++; $display("FAIL reset_rd got %0d want 0", bus.rd_wb); end
    if (bus.wb_data !== 32'h0) begin failures++; $display("FAIL reset_wb_data got %h want 0", bus.wb_data); end
    if (bus.stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_stall got %0d want 0", bus.stall_cnt); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_streaming();
    logic [31:0] exp;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 32'hA000_0000 + 32'(i), 1'(i % 2));
      step();
      exp = (i % 2 == 1) ? 32'hA000_0000 + 32'(i) : 32'h100 + 32'(i);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.rd_wb !== 5'(i) || bus.wb_data !== exp || bus.in_ready !== 1'b1 || bus.reg_write_wb !== 1'b1)
        begin failures++; $display("FAIL stream_%0d got v=%b rd=%0d data=%h rdy=%b rw=%b want v=1 rd=%0d data=%h rdy=1 rw=1", i, bus.out_valid, bus.rd_wb, bus.wb_data, bus.in_ready, bus.reg_write_wb, i, exp); end
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    step();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got v=%b want 0", bus.out_valid); end
    if (bus.stall_cnt !== 4'd0) begin failures++; $display("FAIL stream_stall got %0d want 0", bus.stall_cnt); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd3, 32'h3, 32'h33, 1'b0);
    step();
    checks++;
    if (bus.rd_wb !== 5'd3 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_first got rd=%0d v=%b rdy=%b want rd=3 v=1 rdy=1", bus.rd_wb, bus.out_valid, bus.in_ready); end
    drive(1'b1, 5'd4, 32'h4, 32'h44, 1'b0);
    step();
    checks++;
    if (bus.rd_wb !== 5'd3 || bus.in_ready !== 1'b0 || bus.stall_cnt !== 4'd1) begin failures++; $display("FAIL bp_skid got rd=%0d rdy=%b stall=%0d want rd=3 rdy=0 stall=1", bus.rd_wb, bus.in_ready, bus.stall_cnt); end
    drive(1'b1, 5'd5, 32'h5, 32'h55, 1'b0);
    step();
    checks++;
    if (bus.rd_wb !== 5'd3 || bus.in_ready !== 1'b0 || bus.stall_cnt !== 4'd2) begin failures++; $display("FAIL bp_hold got rd=%0d rdy=%b stall=%0d want rd=3 rdy=0 stall=2", bus.rd_wb, bus.in_ready, bus.stall_cnt); end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.rd_wb !== 5'd4 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_order4 got rd=%0d v=%b rdy=%b want rd=4 v=1 rdy=1", bus.rd_wb, bus.out_valid, bus.in_ready); end
    step();
    checks++;
    if (bus.rd_wb !== 5'd5 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_order5 got rd=%0d v=%b want rd=5 v=1", bus.rd_wb, bus.out_valid); end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 4'd2) begin failures++; $display("FAIL bp_end got v=%b stall=%0d want v=0 stall=2", bus.out_valid, bus.stall_cnt); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd7, 32'h7, 32'h77, 1'b0);
    step();
    drive(1'b1, 5'd8, 32'h8, 32'h88, 1'b0);
    step();
    checks++;
    if (bus.rd_wb !== 5'd7 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_setup got rd=%0d rdy=%b want rd=7 rdy=0", bus.rd_wb, bus.in_ready); end
    drive(1'b1, 5'd9, 32'h9, 32'h99, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.reg_write_wb !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_clear got v=%b rw=%b rdy=%b want 0 0 1", bus.out_valid, bus.reg_write_wb, bus.in_ready); end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.stall_cnt !== 4'd4) begin failures++; $display("FAIL flush_after got v=%b rd=%0d stall=%0d want v=0 stall=4", bus.out_valid, bus.rd_wb, bus.stall_cnt); end
  endtask

  task automatic test_result_mux();
    bus.out_ready = 1'b1;
    drive(1'b1, 5'd10, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1);
    step();
    checks++;
    if (bus.wb_data !== 32'hDEAD_BEEF || bus.mem_to_reg_wb !== 1'b1 || bus.alu_out_wb !== 32'h0000_1234) begin failures++; $display("FAIL mux_load got data=%h m2r=%b alu=%h want deadbeef 1 00001234", bus.wb_data, bus.mem_to_reg_wb, bus.alu_out_wb); end
    drive(1'b1, 5'd11, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0);
    step();
    checks++;
    if (bus.wb_data !== 32'h0000_1234 || bus.mem_to_reg_wb !== 1'b0 || bus.mem_data_wb !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mux_alu got data=%h m2r=%b mem=%h want 00001234 0 deadbeef", bus.wb_data, bus.mem_to_reg_wb, bus.mem_data_wb); end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_saturation();
    logic [3:0] exp = 4'd4;
    bus.out_ready = 1'b0;
    drive(1'b1, 5'd12, 32'hC, 32'hCC, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      exp = (exp == 4'd15) ? 4'd15 : exp + 4'd1;
      if (i == 3 || i == 19) begin
        checks++;
        if (bus.stall_cnt !== exp) begin failures++; $display("FAIL sat_%0d got %0d want %0d", i, bus.stall_cnt, exp); end
      end
    end
    checks++;
    if (bus.stall_cnt !== 4'd15 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL sat_hold got stall=%0d v=%b want 15 1", bus.stall_cnt, bus.out_valid); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd13, 32'hD, 32'hDD, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL arst_setup got rdy=%b v=%b want 0 1", bus.in_ready, bus.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.stall_cnt !== 4'd0 || bus.reg_write_wb !== 1'b0)
      begin failures++; $display("FAIL arst_now got v=%b rdy=%b stall=%0d rw=%b want 0 1 0 0", bus.out_valid, bus.in_ready, bus.stall_cnt, bus.reg_write_wb); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 5'd14, 32'hE, 32'hEE, 1'b0);
    step();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.rd_wb !== 5'd14 || bus.wb_data !== 32'hE) begin failures++; $display("FAIL arst_resume got v=%b rd=%0d data=%h want 1 14 0000000e", bus.out_valid, bus.rd_wb, bus.wb_data); end
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_result_mux();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_skid_stage.md
# wb_skid_stage

Parametrised MEM→WB pipeline boundary register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a writeback-result mux. It replaces the free-running MEM/WB register: the writeback stage can apply backpressure without losing or duplicating instructions, and a redirect can squash in-flight writebacks. It sits between the data-memory stage and the register-file write port.

## Interface
- D_WIDTH, 32, datapath width of ALU result and load data
- RF_SIZE, 5, destination register index width
- CNT_WIDTH, 16, width of the saturating stall counter

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  stage accepts input this cycle; equals NOT skid_valid (registered state only, no combinational path from out_ready)
- alu_out_mem  input  D_WIDTH  ALU result
- r_data_mem  input  D_WIDTH  load data
- rd_mem  input  RF_SIZE  destination register
- reg_write_mem  input  1  instruction writes the register file
- mem_to_reg_mem  input  1  select load data as result
- flush  input  1  squash all held and incoming instructions
- out_valid  output  1  main slot holds a valid instruction
- out_ready  input  1  WB consumes main slot this cycle
- alu_out_wb, mem_data_wb  output  D_WIDTH  main-slot fields
- rd_wb  output  RF_SIZE  main-slot destination
- reg_write_wb  output  1  main-slot reg_write AND out_valid
- mem_to_reg_wb  output  1  main-slot select
- wb_data  output  D_WIDTH  mem_to_reg_wb ? mem_data_wb : alu_out_wb (combinational from main slot)
- stall_cnt  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0, saturating at all-ones

## Operation
- State: main slot (payload + main_valid), skid slot (payload + skid_valid), stall_cnt.
- Accept: acc = in_valid AND in_ready AND NOT flush. Drain: drn = out_valid AND out_ready.
- Per-cycle update (flush = 0):
  - main empty or drn, skid empty: acc → main loads input; else main_valid <= 0 on drn.
  - main empty or drn, skid full: main <= skid; skid_valid <= 0; acc cannot occur (in_ready = 0).
  - main full, no drn, acc: skid loads input.
  - main full, no drn, no acc: hold.
- Order strictly preserved; no instruction dropped or duplicated outside flush.
- flush = 1: main_valid <= 0, skid_valid <= 0; same-cycle input discarded; payload registers may hold stale data but reg_write_wb = 0. flush overrides drain; stall_cnt is not cleared.
- stall_cnt increments when out_valid AND NOT out_ready, holds at 2^CNT_WIDTH-1; cleared only by reset.
- Widths: all payload paths exact-width, no truncation; stall_cnt unsigned.

## Timing
- Reset (rst_n = 0, asynchronous): main_valid = skid_valid = 0, all payload = 0, stall_cnt = 0 → out_valid = 0, reg_write_wb = 0, mem_to_reg_wb = 0, rd_wb = 0, wb_data = 0, in_ready = 1. Reset release is synchronous to clk in the surrounding design; first accept can occur on the first edge after release.
- Latency: input accepted at edge N into an empty stage → out_valid and fields at N+1.
- Throughput: 1 instruction/cycle with out_ready held high; skid never fills.
- Backpressure: out_ready low with main full accepts one more (into skid); in_ready drops the cycle after the skid fills; in_ready returns to 1 the cycle after the skid drains into main.
- Reset asserted mid-operation: all held instructions lost, outputs at reset values immediately (asynchronous).

## Test plan
- Streaming: 8 back-to-back inputs rd=1..8, out_ready=1 → outputs rd=1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1, stall_cnt=0.
- Backpressure: out_ready=0 while sending rd=3,4,5 → main=3, skid=4, in_ready=0, 5 held by MEM; raise out_ready → 3,4,5 emerge in order; stall_cnt equals stalled cycles.
- Flush: main=rd 7, skid=rd 8, flush=1 with in_valid rd 9 → next cycle out_valid=0, reg_write_wb=0, in_ready=1; rd 9 never appears.
- Result mux: alu_out=0x0000_1234, r_data=0xDEAD_BEEF, mem_to_reg=1 → wb_data=0xDEAD_BEEF; mem_to_reg=0 → 0x0000_1234.
- Saturation: CNT_WIDTH=4, out_ready=0 with out_valid=1 for 20 cycles → stall_cnt=15 and holds.
- Async reset mid-stall: both slots full, pull rst_n low between edges → out_valid=0, in_ready=1, stall_cnt=0 without waiting for clk.
